// File: rtl/rs232_pkg.sv
//------------------------------------------------------------------------------
// rs232_pkg : UART register map and bridge FSM state encoding
// Revision  : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rs232_pkg;

  localparam logic [4:0] RS232_DATA_ADDR  = 5'd0;
  localparam int         RS232_RVALID_BIT = 15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_CHECK = 2'd2,
    S_ECHO  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pixel_fifo.sv
//------------------------------------------------------------------------------
// pixel_fifo : first-word-fall-through register FIFO with occupancy count
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pixel_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int                c_AW   = $clog2(DEPTH);
  localparam int                c_LW   = c_AW + 1;
  localparam logic [c_LW-1:0]   c_FULL = c_LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_LW-1:0]  r_level;
  logic             w_pop;

  // Popping an empty FIFO is silently ignored.
  assign w_pop = pop && (r_level != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + c_AW'(1);
      case ({push, w_pop})
        2'b10:   r_level <= r_level + c_LW'(1);
        2'b01:   r_level <= r_level - c_LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign level = r_level;
  assign full  = (r_level == c_FULL);
  assign empty = (r_level == '0);

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

`default_nettype wire

// File: rtl/rs232_pixel_bridge.sv
//------------------------------------------------------------------------------
// rs232_pixel_bridge : polls the UART data register, packs bytes into pixels
//                      and streams them out through a FWFT FIFO.
// Option             : define RS232_ECHO_EN to write every received byte back.
// Revision           : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rs232_pixel_bridge
  import rs232_pkg::*;
#(
  parameter  int CHANNELS    = 3,
  parameter  int FIFO_DEPTH  = 16,
  parameter  int TIMEOUT_CYC = 1_000_000,
  localparam int PIX_W       = 8 * CHANNELS
) (
  input  logic                          avm_clk,
  input  logic                          avm_rst,
  output logic [4:0]                    avm_address,
  output logic                          avm_read,
  input  logic [31:0]                   avm_readdata,
  output logic                          avm_write,
  output logic [31:0]                   avm_writedata,
  input  logic                          avm_waitrequest,
  output logic                          pix_valid,
  input  logic                          pix_ready,
  output logic [PIX_W-1:0]              pix_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt
);

  localparam int                   c_IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [c_IDX_W-1:0]   c_IDX_LST = c_IDX_W'(CHANNELS - 1);
  localparam int                   c_TO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_TO_W-1:0]    c_TO_LST  = c_TO_W'(TIMEOUT_CYC - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_read;
  logic [7:0]           r_byte;
  logic                 r_rvalid;
  logic [c_IDX_W-1:0]   r_byte_idx;
  logic [PIX_W-1:0]     r_pix;
  logic [c_TO_W-1:0]    r_to_cnt;
  logic [7:0]           r_drop;
  logic [PIX_W-1:0]     w_pix;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_unused_rdata;

  assign w_unused_rdata = ^{avm_readdata[31:16], avm_readdata[14:8]};

  assign w_accept = (r_state == S_CHECK) && r_rvalid;
  assign w_push   = w_accept && (r_byte_idx == c_IDX_LST);

  // First received byte lands in the most significant lane.
  always_comb begin
    w_pix = r_pix;
    for (int k = 0; k < CHANNELS; k++) begin
      if (r_byte_idx == c_IDX_W'(k)) w_pix[PIX_W-1-8*k -: 8] = r_byte;
    end
  end

  always_ff @(posedge avm_clk or negedge avm_rst) begin
    if (!avm_rst) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_full) w_state_nxt = S_READ;
      S_READ:  if (!avm_waitrequest) w_state_nxt = S_CHECK;
`ifdef RS232_ECHO_EN
      S_CHECK: w_state_nxt = r_rvalid ? S_ECHO : S_IDLE;
      S_ECHO:  if (!avm_waitrequest) w_state_nxt = S_IDLE;
`else
      S_CHECK: w_state_nxt = S_IDLE;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge avm_clk or negedge avm_rst) begin
    if (!avm_rst) begin
      r_read     <= 1'b0;
      r_byte     <= '0;
      r_rvalid   <= 1'b0;
      r_byte_idx <= '0;
      r_pix      <= '0;
      r_to_cnt   <= '0;
      r_drop     <= '0;
    end else begin
      r_read <= (w_state_nxt == S_READ);
      if ((r_state == S_READ) && !avm_waitrequest) begin
        r_byte   <= avm_readdata[7:0];
        r_rvalid <= avm_readdata[RS232_RVALID_BIT];
      end
      // An accepted byte always beats a timeout expiring on the same edge.
      if (w_accept) begin
        r_pix      <= w_pix;
        r_byte_idx <= w_push ? '0 : r_byte_idx + c_IDX_W'(1);
        r_to_cnt   <= '0;
      end else if (r_byte_idx == '0) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt == c_TO_LST) begin
        r_byte_idx <= '0;
        r_to_cnt   <= '0;
        if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      end else begin
        r_to_cnt <= r_to_cnt + c_TO_W'(1);
      end
    end
  end

`ifdef RS232_ECHO_EN
  logic        r_write;
  logic [31:0] r_wdata;

  always_ff @(posedge avm_clk or negedge avm_rst) begin
    if (!avm_rst) begin
      r_write <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_write <= (w_state_nxt == S_ECHO);
      if (w_accept) r_wdata <= {24'b0, r_byte};
    end
  end

  assign avm_write     = r_write;
  assign avm_writedata = r_wdata;
`else
  assign avm_write     = 1'b0;
  assign avm_writedata = '0;
`endif

  assign avm_address = RS232_DATA_ADDR;
  assign avm_read    = r_read;
  assign drop_cnt    = r_drop;
  assign pix_valid   = !w_empty;

  pixel_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (avm_clk),
    .rst_n (avm_rst),
    .push  (w_push),
    .wdata (w_pix),
    .pop   (pix_valid && pix_ready),
    .rdata (pix_data),
    .level (fifo_level),
    .full  (w_full),
    .empty (w_empty)
  );

endmodule

`default_nettype wire

// File: doc/rs232_pixel_bridge.md
# rs232_pixel_bridge

Avalon-MM master that polls the RS232 UART core's data register, assembles received bytes into CHANNELS-byte pixels, and buffers them in a FIFO that feeds the VGA pixel consumer through a valid/ready handshake. It replaces the single-byte, unbuffered RS232-to-VGA link with a parametrised, back-pressured pixel stream, and adds partial-pixel timeout recovery and optional byte echo.

## Interface
- CHANNELS, 3: bytes per pixel (1 = grey, 3 = RGB); legal values 1..4
- FIFO_DEPTH, 16: pixel FIFO entries; power of two, at least 2
- TIMEOUT_CYC, 1_000_000: idle cycles after which a partially assembled pixel is discarded
- PIX_W (localparam): 8*CHANNELS

Ports:
- avm_clk  in  1  system clock
- avm_rst  in  1  asynchronous active-low reset
- avm_address  out  5  Avalon byte address; always 0 (UART data register)
- avm_read  out  1  Avalon read strobe
- avm_readdata  in  32  bits[7:0] = data, bit 15 = RVALID
- avm_write  out  1  Avalon write strobe (echo only)
- avm_writedata  out  32  echo data, byte in bits[7:0], other bits 0
- avm_waitrequest  in  1  Avalon stall
- pix_valid  out  1  FIFO head valid
- pix_ready  in  1  consumer accepts head
- pix_data  out  PIX_W  FIFO head; first received byte in MSBs
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- drop_cnt  out  8  saturating count of timed-out partial pixels

## Operation
- FSM states: S_IDLE, S_READ, S_CHECK, S_ECHO.
- S_IDLE → S_READ when the FIFO is not full; otherwise stay in S_IDLE. The UART's internal FIFO absorbs back-pressure.
- S_READ: avm_read=1, avm_address=0. Hold until avm_waitrequest=0. On that cycle, register avm_readdata and go to S_CHECK.
- S_CHECK, RVALID=0: go to S_IDLE; no state change.
- S_CHECK, RVALID=1:
  - Store the byte at slot byte_idx; byte 0 goes to pix_data[PIX_W-1 -: 8].
  - If byte_idx==CHANNELS-1, push the pixel and clear byte_idx; otherwise increment byte_idx.
  - Next state is S_ECHO if echo is compiled in, else S_IDLE.
- S_ECHO: avm_write=1, avm_writedata={24'b0,byte}, avm_address=0. Hold until avm_waitrequest=0, then go to S_IDLE. A byte that does not fit in the UART TX FIFO is dropped by the UART; that is accepted behaviour.
- FIFO is first-word-fall-through:
  - pix_valid = (level != 0), and pix_data is the head entry.
  - Pop on pix_valid && pix_ready.
- Push and pop on the same edge: level is unchanged. Pop when empty is ignored.
- Push while full cannot occur:
  - The read is only started when not full, and only this block pushes.
  - Implementation carries an assertion for it.
- Timeout counter:
  - Counts while byte_idx != 0. Cleared on every accepted byte and whenever byte_idx == 0.
  - On reaching TIMEOUT_CYC-1: byte_idx←0, drop_cnt increments, saturating at 255.
  - If a byte is accepted on the same cycle as the timeout, the byte wins: it is stored, and the timeout does not fire.
- CHANNELS=1: every valid byte is pushed, the timeout never fires, and drop_cnt stays 0.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, pix_valid=0, pix_data=0, fifo_level=0, drop_cnt=0; FSM in S_IDLE, byte_idx=0.
- Reset asserted mid-transaction drops avm_read/avm_write immediately (asynchronously). The partial pixel and FIFO contents are lost.
- Minimum poll period with zero wait states: 3 cycles per read (IDLE, READ, CHECK); 4 with echo.
- Push edge is the end of S_CHECK. pix_valid rises the following cycle, i.e. 1 cycle after the final byte is registered.
- fifo_level is registered and updates on the push/pop edge.
- All outputs are registered except pix_valid/pix_data, which are driven directly from the FIFO registers.

## Configuration
- RS232_ECHO_EN defined: S_ECHO is present and every valid received byte is written back to the UART.
- RS232_ECHO_EN undefined: S_ECHO is not generated, avm_write is tied 0, avm_writedata is tied 0, and S_CHECK returns to S_IDLE.

## Structure
- Package rs232_pkg holds:
  - RS232_DATA_ADDR (5'd0) and RS232_RVALID_BIT (15)
  - the state typedef enum logic [1:0] {S_IDLE,S_READ,S_CHECK,S_ECHO}
- Sub-module pixel_fifo (parameters WIDTH, DEPTH): FWFT register FIFO with push, pop, level, full and empty.
- Byte assembly, FSM and timeout logic live in rs232_pixel_bridge.

## Test plan
- CHANNELS=3; feed bytes 0x11, 0x22, 0x33 with RVALID=1 and pix_ready=1 → one pixel 0x112233; pix_valid high 1 cycle after the third S_CHECK; fifo_level 0→1→0.
- avm_waitrequest held high 5 cycles in S_READ → avm_read stays 1 and avm_address stays 0 throughout; data is captured only on the cycle waitrequest falls.
- pix_ready=0, FIFO_DEPTH=4, 15 valid bytes → fifo_level saturates at 4; avm_read stays low while full; raising pix_ready drains 0x..., 4 pixels in order, then reading resumes.
- Two bytes then silence for TIMEOUT_CYC (bench uses 100) → drop_cnt=1, byte_idx=0; the next three bytes form a correct pixel.
- Reads returning RVALID=0 → no push, byte_idx unchanged, FSM cycles IDLE→READ→CHECK.
- With RS232_ECHO_EN: byte 0x5A received → avm_write pulse with avm_writedata=0x0000005A. Reset asserted during S_ECHO → avm_write drops immediately, all outputs return to reset values.
